// File: rtl/ethernet_rx_drain.sv
// Drains complete packets from a receive buffer into a valid/ready stream.
// Dropped and zero-length packets are released without any buffer reads.
module ethernet_rx_drain #(
  parameter int data_width_p = 32,
  parameter int eth_mtu_p    = 2048,
  localparam int addr_w_lp   = $clog2(eth_mtu_p),
  localparam int size_w_lp   = $clog2(eth_mtu_p + 1),
  localparam int keep_w_lp   = data_width_p / 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    drop_i,
  input  logic                    packet_avail_i,
  input  logic [size_w_lp-1:0]    packet_rsize_i,
  output logic                    packet_rvalid_o,
  output logic [addr_w_lp-1:0]    packet_raddr_o,
  input  logic [data_width_p-1:0] packet_rdata_i,
  output logic                    packet_ack_o,
  // Stream handshake: a word moves on every rising edge where m_v_o and
  // m_ready_i are both high; while m_v_o waits, data/keep/last stay frozen.
  output logic                    m_v_o,
  input  logic                    m_ready_i,
  output logic [data_width_p-1:0] m_data_o,
  output logic [keep_w_lp-1:0]    m_keep_o,
  output logic                    m_last_o,
  output logic                    busy_o,
  output logic [15:0]             drain_count_o,
  output logic [15:0]             drop_count_o,
  output logic [1:0]              state_o       // 0 IDLE, 1 STREAM, 2 FLUSH, 3 ACK
);

  localparam int bsh_lp = $clog2(keep_w_lp);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    ACK    = 2'd3
  } state_e;

  state_e                  r_state;
  state_e                  w_next;
  logic                    r_guard;
  logic                    r_is_drop;
  logic [size_w_lp:0]      r_rem;
  logic [addr_w_lp-1:0]    r_addr;
  logic [keep_w_lp-1:0]    r_last_keep;
  logic                    r_inflight;
  logic                    r_infl_last;
  logic [data_width_p-1:0] r_fifo_data [2];
  logic [keep_w_lp-1:0]    r_fifo_keep [2];
  logic [1:0]              r_fifo_last;
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_cnt;
  logic [15:0]             r_drain_cnt;
  logic [15:0]             r_drop_cnt;

  logic                    w_start;
  logic                    w_skip;
  logic                    w_pop;
  logic [2:0]              w_occ;
  logic                    w_issue;
  logic                    w_issue_last;
  logic [size_w_lp:0]      w_sz_round;
  logic [size_w_lp:0]      w_nwords;
  logic [bsh_lp-1:0]       w_tail;
  logic [keep_w_lp-1:0]    w_keep_calc;

  assign w_start = (r_state == IDLE) & ~r_guard & enable_i & packet_avail_i;
  assign w_skip  = drop_i | (packet_rsize_i == '0);
  assign w_pop   = m_v_o & m_ready_i;

  // Buffered plus in-flight words after this cycle's pop must stay under two,
  // so every returning word is guaranteed a FIFO slot.
  assign w_occ        = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue      = (r_state == STREAM) & (r_rem != '0) & (w_occ < 3'd2);
  assign w_issue_last = w_issue & (r_rem == (size_w_lp + 1)'(1));

  assign w_sz_round = {1'b0, packet_rsize_i} + (size_w_lp + 1)'(keep_w_lp - 1);
  assign w_nwords   = w_sz_round >> bsh_lp;
  assign w_tail     = packet_rsize_i[bsh_lp-1:0];

  always_comb begin
    w_keep_calc = '0;
    for (int i = 0; i < keep_w_lp; i++) begin
      w_keep_calc[i] = (w_tail == '0) || (i < int'(w_tail));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_skip ? ACK : STREAM;
      STREAM:  if (w_issue_last) w_next = FLUSH;
      FLUSH:   if (w_pop && m_last_o) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_guard     <= 1'b0;
      r_is_drop   <= 1'b0;
      r_rem       <= '0;
      r_addr      <= '0;
      r_last_keep <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_keep[i] <= '0;
      end
      r_fifo_last <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      // Blocks a restart from an avail level left over from the packet just acked.
      r_guard <= (r_state == ACK);
      if (w_start) begin
        r_is_drop   <= w_skip;
        r_rem       <= w_skip ? '0 : w_nwords;
        r_addr      <= '0;
        r_last_keep <= w_keep_calc;
      end else if (w_issue) begin
        r_rem  <= r_rem - (size_w_lp + 1)'(1);
        r_addr <= r_addr + addr_w_lp'(keep_w_lp);
      end
      r_inflight  <= w_issue;
      r_infl_last <= w_issue_last;
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= packet_rdata_i;
        r_fifo_keep[r_wr_ptr] <= r_infl_last ? r_last_keep : '1;
        r_fifo_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_start && w_skip && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if ((r_state == ACK) && !r_is_drop && (r_drain_cnt != 16'hFFFF))
        r_drain_cnt <= r_drain_cnt + 16'd1;
    end
  end

  assign packet_rvalid_o = w_issue;
  assign packet_raddr_o  = w_issue ? r_addr : '0;
  assign packet_ack_o    = (r_state == ACK);
  assign busy_o          = (r_state != IDLE);
  assign m_v_o           = (r_cnt != '0);
  assign m_data_o        = m_v_o ? r_fifo_data[r_rd_ptr] : '0;
  assign m_keep_o        = m_v_o ? r_fifo_keep[r_rd_ptr] : '0;
  assign m_last_o        = m_v_o & r_fifo_last[r_rd_ptr];
  assign drain_count_o   = r_drain_cnt;
  assign drop_count_o    = r_drop_cnt;
  assign state_o         = r_state;

endmodule

// File: tb/tb_ethernet_rx_drain.sv
// Bench for ethernet_rx_drain: 32- and 64-bit instances share one stimulus
// path; a byte-array receiver model produces the expected word stream.
module tb_ethernet_rx_drain;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic        sel64, enable, drop, avail, m_ready;
  logic [11:0] rsize;
  logic [63:0] rdata;
  logic        en32, en64;
  assign en32 = enable & ~sel64;
  assign en64 = enable & sel64;

  logic        rv32, rv64, ack32, ack64, v32, v64, l32, l64, b32, b64;
  logic [10:0] ra32, ra64;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [3:0]  k32;
  logic [7:0]  k64;
  logic [15:0] dr32, dr64, dp32, dp64;
  logic [1:0]  st32, st64;

  ethernet_rx_drain #(.data_width_p(32), .eth_mtu_p(2048)) u_dut32 (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en32), .drop_i(drop),
    .packet_avail_i(avail), .packet_rsize_i(rsize),
    .packet_rvalid_o(rv32), .packet_raddr_o(ra32), .packet_rdata_i(rdata[31:0]),
    .packet_ack_o(ack32), .m_v_o(v32), .m_ready_i(m_ready), .m_data_o(d32),
    .m_keep_o(k32), .m_last_o(l32), .busy_o(b32),
    .drain_count_o(dr32), .drop_count_o(dp32), .state_o(st32));

  ethernet_rx_drain #(.data_width_p(64), .eth_mtu_p(2048)) u_dut64 (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en64), .drop_i(drop),
    .packet_avail_i(avail), .packet_rsize_i(rsize),
    .packet_rvalid_o(rv64), .packet_raddr_o(ra64), .packet_rdata_i(rdata),
    .packet_ack_o(ack64), .m_v_o(v64), .m_ready_i(m_ready), .m_data_o(d64),
    .m_keep_o(k64), .m_last_o(l64), .busy_o(b64),
    .drain_count_o(dr64), .drop_count_o(dp64), .state_o(st64));

  logic        o_rvalid, o_ack, o_v, o_last, o_busy;
  logic [10:0] o_raddr;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic [15:0] o_drain, o_drop;
  logic [1:0]  o_state;
  assign o_rvalid = sel64 ? rv64 : rv32;
  assign o_raddr  = sel64 ? ra64 : ra32;
  assign o_ack    = sel64 ? ack64 : ack32;
  assign o_v      = sel64 ? v64 : v32;
  assign o_last   = sel64 ? l64 : l32;
  assign o_busy   = sel64 ? b64 : b32;
  assign o_data   = sel64 ? d64 : {32'd0, d32};
  assign o_keep   = sel64 ? k64 : {4'd0, k32};
  assign o_drain  = sel64 ? dr64 : dr32;
  assign o_drop   = sel64 ? dp64 : dp32;
  assign o_state  = sel64 ? st64 : st32;

  // ---------------- model / scoreboard state ----------------
  logic [7:0]  mem [0:2047];
  logic [72:0] exp_q[$];          // {last, keep[7:0], data[63:0]}
  int          n_tests, n_fail;
  int          cyc, reads, xfers, acks, exp_addr, pend_addr, start_cyc, nb;
  logic        pend_valid, prev_stall, consec;
  logic [72:0] prev_word;
  int          exp_drain[2], exp_drop[2];
  logic        drv_avail, drv_en, drv_drop;
  int          drv_size;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input int addr);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < nb; j++) w[8*j +: 8] = mem[(addr + j) % 2048];
    return w;
  endfunction

  task automatic build_exp(input int size, input logic drp);
    int n, tail;
    logic [7:0] kp;
    exp_q.delete();
    if (drp || size == 0) return;
    n = (size + nb - 1) / nb;
    tail = size % nb;
    for (int k = 0; k < n; k++) begin
      kp = (nb == 8) ? 8'hFF : 8'h0F;
      if (k == n - 1 && tail != 0) kp = 8'((1 << tail) - 1);
      exp_q.push_back({(k == n - 1), kp, mem_word(k * nb)});
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic rdy);
    logic [72:0] e;
    @(negedge clk);
    avail   = drv_avail;
    enable  = drv_en;
    drop    = drv_drop;
    rsize   = 12'(drv_size);
    m_ready = rdy;
    rdata   = pend_valid ? mem_word(pend_addr) : {$urandom, $urandom};
    pend_valid = 1'b0;
    #1;
    cyc++;
    if (prev_stall) begin
      check("hold_valid", 64'(o_v), 64'd1);
      check("hold_data", o_data, prev_word[63:0]);
      check("hold_keep", 64'(o_keep), 64'(prev_word[71:64]));
      check("hold_last", 64'(o_last), 64'(prev_word[72]));
    end
    prev_stall = o_v & ~rdy;
    prev_word  = {o_last, o_keep, o_data};
    if (o_v && rdy) begin
      xfers++;
      check("word_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data", o_data, e[63:0]);
        check("keep", 64'(o_keep), 64'(e[71:64]));
        check("last", 64'(o_last), 64'(e[72]));
      end
    end
    if (o_rvalid) begin
      reads++;
      check("raddr", 64'(o_raddr), 64'(exp_addr));
      if (consec) check("read_cycle", 64'(cyc), 64'(start_cyc + reads));
      exp_addr  += nb;
      pend_valid = 1'b1;
      pend_addr  = int'(o_raddr);
    end else begin
      check("raddr_idle", 64'(o_raddr), 64'd0);
    end
    check("in_flight_limit", 64'((reads - xfers) <= 2), 64'd1);
    if (o_ack) acks++;
  endtask

  task automatic mid_reset(input int size);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rvalid", 64'(o_rvalid), 64'd0);
    check("rst_raddr", 64'(o_raddr), 64'd0);
    check("rst_ack", 64'(o_ack), 64'd0);
    check("rst_v", 64'(o_v), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_data", o_data, 64'd0);
    check("rst_keep", 64'(o_keep), 64'd0);
    check("rst_drain", 64'(o_drain), 64'd0);
    check("rst_drop", 64'(o_drop), 64'd0);
    exp_drain = '{0, 0};
    exp_drop  = '{0, 0};
    build_exp(size, 1'b0);
    exp_addr = 0; reads = 0; xfers = 0; acks = 0;
    pend_valid = 1'b0; prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_cyc = cyc;
  endtask

  // mode: 0 ready high, 1 toggling, 2 stalled 20 cycles, 3 random
  task automatic run_packet(input logic w64, input int size, input logic drp,
                            input int mode, input int rst_after);
    int   n, budget, t_ack, d;
    logic done, did_rst, rdy, skip;
    sel64 = w64;
    nb    = w64 ? 8 : 4;
    d     = w64 ? 1 : 0;
    skip  = drp || size == 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    build_exp(size, drp);
    n = (size + nb - 1) / nb;
    exp_addr = 0; reads = 0; xfers = 0; acks = 0; t_ack = 0;
    pend_valid = 1'b0; prev_stall = 1'b0;
    consec    = (mode == 0);
    drv_avail = 1'b1; drv_en = 1'b1; drv_drop = drp; drv_size = size;
    start_cyc = cyc + 1;
    budget = 4 * n + 60;
    done = 1'b0; did_rst = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (i % 2 == 0);
        2:       rdy = (i >= 20);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2 && i == 20) check("stalled_reads", 64'(reads <= 2), 64'd1);
      step(rdy);
      if (i == 0 && rst_after == 0) begin
        drv_en   = 1'($urandom_range(0, 1));
        drv_drop = 1'($urandom_range(0, 1));
      end
      check("busy", 64'(o_busy), 64'(cyc > start_cyc));
      if (o_ack) begin
        done  = 1'b1;
        t_ack = cyc;
      end
      if (rst_after > 0 && !did_rst && xfers == rst_after) begin
        mid_reset(size);
        did_rst = 1'b1;
      end
    end
    check("ack_seen", 64'(done), 64'd1);
    if (done) begin
      check("ack_no_read", 64'(o_rvalid), 64'd0);
      check("ack_all_words", 64'(exp_q.size()), 64'd0);
      check("ack_reads", 64'(reads), skip ? 64'd0 : 64'(n));
      if (skip) begin
        check("ack_latency", 64'(t_ack), 64'(start_cyc + 1));
        exp_drop[d]++;
      end else begin
        exp_drain[d]++;
      end
      step(1'b1);
      check("ack_single", 64'(o_ack), 64'd0);
      check("idle_after_ack", 64'(o_busy), 64'd0);
      drv_avail = 1'b0; drv_en = 1'b0;
      step(1'b1);
      check("guard_idle", 64'(o_busy), 64'd0);
      check("ack_count", 64'(acks), 64'd1);
      check("drain_count", 64'(o_drain), 64'(exp_drain[d]));
      check("drop_count", 64'(o_drop), 64'(exp_drop[d]));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic w;
    int   sz, md;
    logic dp;
    n_tests = 0; n_fail = 0; cyc = 0; nb = 4;
    rst_n = 1'b0; sel64 = 1'b0; enable = 1'b0; drop = 1'b0; avail = 1'b0;
    m_ready = 1'b0; rsize = '0; rdata = '0;
    drv_avail = 1'b0; drv_en = 1'b0; drv_drop = 1'b0; drv_size = 0;
    pend_valid = 1'b0; prev_stall = 1'b0; consec = 1'b0; prev_word = '0;
    exp_drain = '{0, 0};
    exp_drop  = '{0, 0};
    repeat (3) @(negedge clk);
    #1;
    check("reset_rvalid", 64'(o_rvalid), 64'd0);
    check("reset_ack", 64'(o_ack), 64'd0);
    check("reset_v", 64'(o_v), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_state", 64'(o_state), 64'd0);
    check("reset_drain", 64'(o_drain), 64'd0);
    check("reset_drop", 64'(o_drop), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_packet(1'b0, 10,   1'b0, 0, 0);   // 3 words, tail keep 0011
    run_packet(1'b1, 16,   1'b0, 1, 0);   // two full 64-bit words, toggled ready
    run_packet(1'b0, 60,   1'b1, 0, 0);   // explicit drop
    run_packet(1'b1, 0,    1'b0, 0, 0);   // zero length acts as drop
    run_packet(1'b0, 2048, 1'b0, 2, 0);   // full MTU behind a stall
    run_packet(1'b0, 20,   1'b0, 0, 3);   // reset after 3 of 5 words
    run_packet(1'b1, 13,   1'b0, 3, 0);   // 64-bit tail keep 1F
    run_packet(1'b1, 2048, 1'b0, 0, 0);   // 64-bit full MTU

    for (int k = 0; k < 12; k++) begin
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 17) : $urandom_range(1, 2048);
      dp = ($urandom_range(0, 7) == 0);
      md = $urandom_range(0, 2);
      if (md == 2) md = 3;
      run_packet(w, sz, dp, md, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
